// File: rtl/aes_channel_ctrl.sv
// Round-robin scheduler of NUM_CH rx/tx FIFO pairs onto one AES core and key generator, with per-channel mode/key state.
// Request pulse to key_load/aes_start: 2 cycles; tx_full stalls ENQ (watchdog frozen), missing core handshakes abort via the watchdog.
module aes_channel_ctrl #(
    parameter int NUM_CH    = 4,
    parameter int CH_W      = $clog2(NUM_CH),
    parameter int TIMEOUT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   ch_key_pulse,
    input  logic [NUM_CH-1:0]   ch_enc_pulse,
    input  logic [NUM_CH-1:0]   ch_dec_pulse,
    input  logic [NUM_CH-1:0]   rx_empty,
    input  logic [NUM_CH-1:0]   tx_full,
    input  logic                aes_accepted,
    input  logic                aes_done,
    output logic [NUM_CH-1:0]   rcv_deq,
    output logic [NUM_CH-1:0]   trans_enq,
    output logic                key_load,
    output logic                aes_start,
    output logic                aes_is_encrypt,
    output logic [CH_W-1:0]     cur_ch,
    output logic [4*NUM_CH-1:0] ch_status,
    output logic                busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_KEY, S_START, S_WAIT_ACC, S_WAIT_DONE, S_ENQ
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [1:0]            r_mode [NUM_CH];
    logic [NUM_CH-1:0]     r_key_valid;
    logic [NUM_CH-1:0]     r_tmo_err;
    logic [CH_W-1:0]       r_cur_ch;
    logic [CH_W-1:0]       r_rr_ptr;
    logic                  r_is_enc;
    logic                  r_done_seen;
    logic [TIMEOUT_W-1:0]  r_wdog;

    logic [NUM_CH-1:0]     w_elig;
    logic                  w_sel_vld;
    logic [CH_W-1:0]       w_sel_ch;
    logic [CH_W-1:0]       w_scan_idx;
    logic                  w_timeout;
    logic [TIMEOUT_W-1:0]  w_wdog_nxt;

    always_comb begin
        ch_status = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_elig[c] = !rx_empty[c] &&
                        ((r_mode[c] == 2'b11) || ((^r_mode[c]) && r_key_valid[c]));
            ch_status[4*c +: 4] = {r_tmo_err[c], r_key_valid[c], r_mode[c]};
        end
    end

    // Scan downward so the eligible channel closest to rr_ptr is written last and wins.
    always_comb begin
        w_sel_vld  = 1'b0;
        w_sel_ch   = '0;
        w_scan_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_scan_idx = CH_W'((int'(r_rr_ptr) + i) % NUM_CH);
            if (w_elig[w_scan_idx]) begin
                w_sel_vld = 1'b1;
                w_sel_ch  = w_scan_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        key_load    = 1'b0;
        aes_start   = 1'b0;
        rcv_deq     = '0;
        trans_enq   = '0;
        w_timeout   = 1'b0;
        w_wdog_nxt  = r_wdog + 1'b1;
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    if (w_sel_vld)
                        w_state_nxt = (r_mode[w_sel_ch] == 2'b11) ? S_KEY : S_START;
                end
                S_KEY: begin
                    key_load          = 1'b1;
                    rcv_deq[r_cur_ch] = 1'b1;
                    w_state_nxt       = S_IDLE;
                end
                S_START: begin
                    aes_start   = 1'b1;
                    w_state_nxt = S_WAIT_ACC;
                end
                S_WAIT_ACC: begin
                    if (aes_accepted) begin
                        rcv_deq[r_cur_ch] = 1'b1;
                        w_state_nxt       = S_WAIT_DONE;
                    end else if (&w_wdog_nxt) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_WAIT_DONE: begin
                    if (r_done_seen || aes_done) begin
                        if (!tx_full[r_cur_ch])
                            w_state_nxt = S_ENQ;
                    end else if (&w_wdog_nxt) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_ENQ: begin
                    trans_enq[r_cur_ch] = 1'b1;
                    w_state_nxt         = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_key_valid <= '0;
            r_tmo_err   <= '0;
            r_cur_ch    <= '0;
            r_rr_ptr    <= '0;
            r_is_enc    <= 1'b0;
            r_done_seen <= 1'b0;
            r_wdog      <= '0;
            for (int c = 0; c < NUM_CH; c++)
                r_mode[c] <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_sel_vld) begin
                r_cur_ch <= w_sel_ch;
                r_rr_ptr <= (w_sel_ch == CH_W'(NUM_CH - 1)) ? '0 : w_sel_ch + 1'b1;
                r_is_enc <= (r_mode[w_sel_ch] == 2'b01);
            end
            if (r_state == S_START)
                r_wdog <= '0;
            else if (r_state == S_WAIT_ACC || (r_state == S_WAIT_DONE && !r_done_seen))
                r_wdog <= w_wdog_nxt;
            if (r_state == S_WAIT_DONE && aes_done)
                r_done_seen <= 1'b1;
            if (r_state == S_ENQ || w_timeout)
                r_done_seen <= 1'b0;
            if (r_state == S_KEY) begin
                r_mode[r_cur_ch]      <= 2'b00;
                r_key_valid[r_cur_ch] <= 1'b1;
            end
            if (w_timeout) begin
                r_tmo_err[r_cur_ch] <= 1'b1;
                r_mode[r_cur_ch]    <= 2'b00;
            end
            // Fresh requests override the FSM's own mode updates on the same channel.
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_key_pulse[c]) begin
                    r_mode[c]    <= 2'b11;
                    r_tmo_err[c] <= 1'b0;
                end else if (ch_dec_pulse[c]) begin
                    r_mode[c] <= 2'b10;
                end else if (ch_enc_pulse[c]) begin
                    r_mode[c] <= 2'b01;
                end
            end
        end
    end

    assign aes_is_encrypt = r_is_enc;
    assign cur_ch         = r_cur_ch;
    assign busy           = (r_state != S_IDLE) && !reset;

endmodule

// File: tb/tb_aes_channel_ctrl.sv
// Directed bench for aes_channel_ctrl (4 channels, 4-bit watchdog) with hand-computed expectations.
`timescale 1ns/1ps
module tb_aes_channel_ctrl;
    localparam int NUM_CH    = 4;
    localparam int CH_W      = 2;
    localparam int TIMEOUT_W = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NUM_CH-1:0]   ch_key_pulse = '0;
    logic [NUM_CH-1:0]   ch_enc_pulse = '0;
    logic [NUM_CH-1:0]   ch_dec_pulse = '0;
    logic [NUM_CH-1:0]   rx_empty = '1;
    logic [NUM_CH-1:0]   tx_full = '0;
    logic                aes_accepted = 1'b0;
    logic                aes_done = 1'b0;
    logic [NUM_CH-1:0]   rcv_deq;
    logic [NUM_CH-1:0]   trans_enq;
    logic                key_load;
    logic                aes_start;
    logic                aes_is_encrypt;
    logic [CH_W-1:0]     cur_ch;
    logic [4*NUM_CH-1:0] ch_status;
    logic                busy;

    int n_cmp = 0;
    int n_err = 0;

    aes_channel_ctrl #(.NUM_CH(NUM_CH), .CH_W(CH_W), .TIMEOUT_W(TIMEOUT_W)) dut (
        .clk(clk), .reset(reset),
        .ch_key_pulse(ch_key_pulse), .ch_enc_pulse(ch_enc_pulse), .ch_dec_pulse(ch_dec_pulse),
        .rx_empty(rx_empty), .tx_full(tx_full),
        .aes_accepted(aes_accepted), .aes_done(aes_done),
        .rcv_deq(rcv_deq), .trans_enq(trans_enq), .key_load(key_load), .aes_start(aes_start),
        .aes_is_encrypt(aes_is_encrypt), .cur_ch(cur_ch), .ch_status(ch_status), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (aes_start) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit ok;
        logic [1:0] exp_seq [4];
        exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd1; exp_seq[3] = 2'd2;

        // Reset with random inputs
        step();
        reset = 1'b1;
        ch_key_pulse = 4'($urandom); ch_enc_pulse = 4'($urandom); ch_dec_pulse = 4'($urandom);
        rx_empty = 4'($urandom); tx_full = 4'($urandom);
        aes_accepted = 1'($urandom); aes_done = 1'($urandom);
        smp();
        step();
        ch_key_pulse = 4'($urandom); ch_enc_pulse = 4'($urandom); rx_empty = 4'($urandom);
        smp();
        check_eq("rst_pulses", {rcv_deq, trans_enq, key_load, aes_start}, 32'h0);
        check_eq("rst_state", {aes_is_encrypt, cur_ch, busy}, 32'h0);
        check_eq("rst_status", ch_status, 32'h0);
        step();
        reset = 1'b0;
        ch_key_pulse = '0; ch_enc_pulse = '0; ch_dec_pulse = '0;
        rx_empty = 4'hF; tx_full = '0; aes_accepted = 1'b0; aes_done = 1'b0;

        // Key then encrypt on channel 0
        step();
        rx_empty = 4'b1110; ch_key_pulse = 4'b0001;
        step();
        ch_key_pulse = '0;
        smp();
        check_eq("t2_key_early", key_load, 1'b0);
        step();
        smp();
        check_eq("t2_key_load", key_load, 1'b1);
        check_eq("t2_key_deq", rcv_deq, 4'b0001);
        check_eq("t2_key_ch", cur_ch, 2'd0);
        step();
        smp();
        check_eq("t2_key_once", key_load, 1'b0);
        check_eq("t2_status_key", ch_status[3:0], 4'b0100);
        step();
        ch_enc_pulse = 4'b0001;
        step();
        ch_enc_pulse = '0;
        step();
        smp();
        check_eq("t2_start", {aes_start, aes_is_encrypt}, 2'b11);
        step();
        aes_accepted = 1'b1;
        smp();
        check_eq("t2_acc_deq", rcv_deq, 4'b0001);
        step();
        aes_accepted = 1'b0;
        smp();
        check_eq("t2_wait_done", {busy, rcv_deq}, 5'b1_0000);
        step();
        aes_done = 1'b1;
        smp();
        check_eq("t2_enq_early", trans_enq, 4'b0000);
        step();
        aes_done = 1'b0; rx_empty = 4'hF;
        smp();
        check_eq("t2_enq", trans_enq, 4'b0001);
        step();
        smp();
        check_eq("t2_after", {trans_enq, busy}, 5'b0);
        check_eq("t2_status_enc", ch_status[3:0], 4'b0101);

        // Round robin between channels 1 and 2
        step();
        rx_empty = 4'b1001; ch_key_pulse = 4'b0110;
        step();
        ch_key_pulse = '0;
        repeat (5) step();
        smp();
        check_eq("t3_keys", {ch_status[11:8], ch_status[7:4]}, 8'h44);
        step();
        ch_enc_pulse = 4'b0110;
        step();
        ch_enc_pulse = '0;
        for (int j = 0; j < 4; j++) begin
            wait_start(ok);
            check_eq("t3_start_seen", ok, 1'b1);
            check_eq("t3_cur_ch", cur_ch, exp_seq[j]);
            check_eq("t3_enc", aes_is_encrypt, 1'b1);
            if (j == 3) rx_empty = 4'hF;
            step(); step(); step();
            aes_accepted = 1'b1;
            smp();
            check_eq("t3_deq", rcv_deq, 4'b0001 << exp_seq[j]);
            step();
            aes_accepted = 1'b0;
            step();
            aes_done = 1'b1;
            step();
            aes_done = 1'b0;
            smp();
            check_eq("t3_enq", {rcv_deq, trans_enq}, {4'b0000, 4'b0001 << exp_seq[j]});
            step();
        end

        // Decrypt request without a key is never served
        rx_empty = 4'b0111; ch_dec_pulse = 4'b1000;
        step();
        ch_dec_pulse = '0;
        for (int i = 0; i < 6; i++) begin
            smp();
            check_eq("t4_idle", {busy, aes_start, key_load}, 3'b000);
            step();
        end
        check_eq("t4_status", ch_status[15:12], 4'b0010);

        // tx_full stall after done
        rx_empty = 4'b0101;
        wait_start(ok);
        check_eq("t5_start_seen", ok, 1'b1);
        check_eq("t5_cur_ch", {cur_ch, aes_is_encrypt}, 3'b01_1);
        rx_empty = 4'b0111;
        step();
        aes_accepted = 1'b1; tx_full = 4'b0010;
        smp();
        check_eq("t5_deq", rcv_deq, 4'b0010);
        step();
        aes_accepted = 1'b0; aes_done = 1'b1;
        smp();
        check_eq("t5_stall0", trans_enq, 4'b0000);
        step();
        aes_done = 1'b0;
        for (int i = 0; i < 19; i++) begin
            smp();
            check_eq("t5_stall", {busy, trans_enq}, 5'b1_0000);
            step();
        end
        tx_full = '0;
        smp();
        check_eq("t5_release", trans_enq, 4'b0000);
        step();
        smp();
        check_eq("t5_enq", trans_enq, 4'b0010);
        step();
        smp();
        check_eq("t5_once", trans_enq, 4'b0000);
        check_eq("t5_status", ch_status[7:4], 4'b0101);

        // Watchdog: no aes_accepted on channel 2
        step();
        rx_empty = 4'b0011;
        wait_start(ok);
        check_eq("t6_start_seen", ok, 1'b1);
        check_eq("t6_cur_ch", cur_ch, 2'd2);
        rx_empty = 4'b0111;
        for (int i = 0; i < 15; i++) begin
            step();
            smp();
            check_eq("t6_wait_acc", {busy, rcv_deq, trans_enq}, 9'b1_0000_0000);
        end
        step();
        smp();
        check_eq("t6_idle", busy, 1'b0);
        check_eq("t6_status", ch_status[11:8], 4'b1100);
        for (int i = 0; i < 3; i++) begin
            step();
            smp();
            check_eq("t6_no_retry", {busy, aes_start}, 2'b00);
        end
        step();
        rx_empty = 4'b0011; ch_key_pulse = 4'b0100;
        step();
        ch_key_pulse = '0;
        smp();
        check_eq("t6_err_clear", ch_status[11:8], 4'b0111);
        step();
        smp();
        check_eq("t6_rekey", {key_load, rcv_deq, cur_ch}, {1'b1, 4'b0100, 2'd2});

        // Reset mid-job suppresses pulses
        step();
        rx_empty = 4'b1011; ch_enc_pulse = 4'b0100;
        step();
        ch_enc_pulse = '0;
        wait_start(ok);
        check_eq("t7_start_seen", ok, 1'b1);
        step();
        reset = 1'b1; aes_accepted = 1'b1;
        smp();
        check_eq("t7_rst_pulse", {busy, rcv_deq}, 5'b0);
        step();
        reset = 1'b0; aes_accepted = 1'b0; rx_empty = 4'hF;
        smp();
        check_eq("t7_rst_state", {ch_status, cur_ch, busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
